// File: rtl/load_store_unit_if.sv
// Request/response handshake bundle between the datapath and the load/store unit.
interface load_store_unit_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 15
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  resp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );
  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit with integrated byte-enabled RAM, sized/extended loads, misalign detection.
// Optional statistics counters enabled by defining LSU_STATS_EN.
module load_store_unit #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 15,
  parameter int RD_LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  load_store_unit_if.slave    bus,
  output logic [15:0]         ld_count,
  output logic [15:0]         st_count,
  output logic [15:0]         err_count
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = ADDR_WIDTH - OFF_W;
  localparam int WORDS = 2 ** IDX_W;
  localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                state, state_n;
  logic [LAT_W-1:0]      lat_cnt, lat_n;
  logic [DATA_WIDTH-1:0] mem [WORDS];
  logic [DATA_WIDTH-1:0] pipe_data;
  logic                  pipe_err;

  logic [1:0]            lg;
  int                    nbytes;
  logic [OFF_W-1:0]      lane;
  logic [IDX_W-1:0]      idx;
  logic                  mis, sign, accept;
  logic [BYTES-1:0]      be;
  logic [DATA_WIDTH-1:0] wshift, rshift, ld_ext;

  assign lane = bus.req_addr[OFF_W-1:0];
  assign idx  = bus.req_addr[ADDR_WIDTH-1:OFF_W];

  // Double collapses to a full word when the word is narrower than 64 bits.
  always_comb begin
    lg     = (int'(bus.req_size) > OFF_W) ? 2'(OFF_W) : bus.req_size;
    nbytes = 1 << lg;
    mis    = 1'b0;
    for (int i = 0; i < OFF_W; i++)
      if (i < int'(lg) && lane[i]) mis = 1'b1;
    for (int b = 0; b < BYTES; b++)
      be[b] = (b >= int'(lane)) && (b < int'(lane) + nbytes);
    wshift = bus.req_wdata << {lane, 3'b000};
    rshift = mem[idx] >> {lane, 3'b000};
    sign   = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++)
      if (i == nbytes * 8 - 1) sign = rshift[i];
    for (int i = 0; i < DATA_WIDTH; i++)
      ld_ext[i] = (i < nbytes * 8) ? rshift[i] : (bus.req_signed & sign);
  end

  assign accept = rst && bus.req_valid &&
                  ((state == S_IDLE) || (state == S_RESP && bus.resp_ready));

  always_comb begin
    state_n       = state;
    lat_n         = lat_cnt;
    bus.req_ready = 1'b0;
    case (state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          state_n = S_WAIT;
          lat_n   = LAT_W'(RD_LATENCY - 1);
        end
      end
      S_WAIT: begin
        if (lat_cnt == '0) state_n = S_RESP;
        else               lat_n   = lat_cnt - 1'b1;
      end
      S_RESP: begin
        bus.req_ready = bus.resp_ready;
        if (bus.resp_ready) begin
          if (bus.req_valid) begin
            state_n = S_WAIT;
            lat_n   = LAT_W'(RD_LATENCY - 1);
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Stores commit on the accept edge; misaligned stores never touch the array.
  always_ff @(posedge clk) begin
    if (accept && bus.req_we && !mis)
      for (int b = 0; b < BYTES; b++)
        if (be[b]) mem[idx][b*8 +: 8] <= wshift[b*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= S_IDLE;
      lat_cnt        <= '0;
      pipe_data      <= '0;
      pipe_err       <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      state          <= state_n;
      lat_cnt        <= lat_n;
      bus.resp_valid <= (state_n == S_RESP);
      if (accept) begin
        pipe_data <= (bus.req_we || mis) ? '0 : ld_ext;
        pipe_err  <= mis;
      end
      if (state == S_WAIT && state_n == S_RESP) begin
        bus.resp_data <= pipe_data;
        bus.resp_err  <= pipe_err;
      end else if (state == S_RESP && state_n != S_RESP) begin
        bus.resp_data <= '0;
        bus.resp_err  <= 1'b0;
      end
    end
  end

`ifdef LSU_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      ld_count  <= '0;
      st_count  <= '0;
      err_count <= '0;
    end else if (accept) begin
      if (mis) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 1'b1;
      end else if (bus.req_we) begin
        if (st_count != 16'hFFFF) st_count <= st_count + 1'b1;
      end else begin
        if (ld_count != 16'hFFFF) ld_count <= ld_count + 1'b1;
      end
    end
  end
`else
  assign ld_count  = '0;
  assign st_count  = '0;
  assign err_count = '0;
`endif
endmodule
